// File: rtl/fetch_predict_unit.sv
// Fetch stage with an 8-entry direct-mapped BTB (2-bit counters) and the IF/ID pipeline register.
module fetch_predict_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        PC_stall,
    input  logic        IF_ID_stall,
    input  logic        IF_flush,
    input  logic        update_PC,
    input  logic [15:0] actual_target,
    input  logic        ID_is_branch,
    input  logic        ID_taken,
    input  logic [15:0] ID_PC_curr,
    input  logic [15:0] ID_branch_target,
    input  logic [15:0] instr_data,
    output logic [15:0] PC_curr,
    output logic [15:0] IF_ID_PC_curr,
    output logic [15:0] IF_ID_PC_next,
    output logic [15:0] IF_ID_instr,
    output logic        IF_ID_pred_taken,
    output logic [15:0] IF_ID_pred_target
);

    localparam int unsigned PC_W      = 16;
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned TAG_W     = 12;
    localparam int unsigned CTR_W     = 2;
    localparam int unsigned ENTRIES   = 8;
    localparam logic [3:0]  OP_HLT    = 4'hF;
    localparam logic [CTR_W-1:0] CTR_RESET = 2'b01;
    localparam logic [CTR_W-1:0] CTR_ALLOC = 2'b10;
    localparam logic [CTR_W-1:0] CTR_MAX   = 2'b11;
    localparam logic [CTR_W-1:0] CTR_MIN   = 2'b00;

    // BTB storage
    logic                 valid_q  [ENTRIES];
    logic [TAG_W-1:0]     tag_q    [ENTRIES];
    logic [PC_W-1:0]      target_q [ENTRIES];
    logic [CTR_W-1:0]     ctr_q    [ENTRIES];

    // Fetch PC and IF/ID register
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] if_id_pc_curr_q;
    logic [PC_W-1:0] if_id_pc_next_q;
    logic [PC_W-1:0] if_id_instr_q;
    logic            if_id_pred_taken_q;
    logic [PC_W-1:0] if_id_pred_target_q;

    logic [IDX_W-1:0] look_idx;
    logic [TAG_W-1:0] look_tag;
    logic             pred_taken;
    logic [PC_W-1:0]  pred_target;
    logic [PC_W-1:0]  pc_plus2;

    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_en;
    logic             upd_hit;

    // The BTB only needs the halfword-aligned part of the branch PC
    logic unused_id_pc_lsb;
    assign unused_id_pc_lsb = ID_PC_curr[0];

    // Combinational BTB lookup on the current fetch PC (sees pre-update contents)
    always_comb begin
        look_idx    = pc_q[3:1];
        look_tag    = pc_q[15:4];
        pred_taken  = valid_q[look_idx] && (tag_q[look_idx] == look_tag) && ctr_q[look_idx][1];
        pred_target = target_q[look_idx];
        pc_plus2    = pc_q + PC_W'(2);
    end

    // Next-PC selection: stall, redirect, HLT hold, prediction, sequential
    always_comb begin
        pc_d = pc_plus2;
        if (PC_stall) begin
            pc_d = pc_q;
        end else if (update_PC) begin
            pc_d = actual_target;
        end else if (instr_data[15:12] == OP_HLT) begin
            pc_d = pc_q;
        end else if (pred_taken) begin
            pc_d = pred_target;
        end
    end

    // BTB update decode for the branch resolved in ID
    always_comb begin
        upd_idx = ID_PC_curr[3:1];
        upd_tag = ID_PC_curr[15:4];
        upd_en  = ID_is_branch && !IF_ID_stall;
        upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    end

    // PC register
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    // BTB state: reset invalidates, hits train the counter, taken misses allocate
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_RESET;
            end
        end else if (upd_en) begin
            if (upd_hit) begin
                if (ID_taken) begin
                    target_q[upd_idx] <= ID_branch_target;
                    if (ctr_q[upd_idx] != CTR_MAX) begin
                        ctr_q[upd_idx] <= ctr_q[upd_idx] + CTR_W'(1);
                    end
                end else if (ctr_q[upd_idx] != CTR_MIN) begin
                    ctr_q[upd_idx] <= ctr_q[upd_idx] - CTR_W'(1);
                end
            end else if (ID_taken) begin
                valid_q[upd_idx]  <= 1'b1;
                tag_q[upd_idx]    <= upd_tag;
                target_q[upd_idx] <= ID_branch_target;
                ctr_q[upd_idx]    <= CTR_ALLOC;
            end
        end
    end

    // IF/ID pipeline register: reset/flush clear to a NOP, stall holds
    always_ff @(posedge clk) begin
        if (rst) begin
            if_id_pc_curr_q     <= '0;
            if_id_pc_next_q     <= '0;
            if_id_instr_q       <= '0;
            if_id_pred_taken_q  <= 1'b0;
            if_id_pred_target_q <= '0;
        end else if (IF_ID_stall) begin
            if_id_pc_curr_q     <= if_id_pc_curr_q;
        end else if (IF_flush) begin
            if_id_pc_curr_q     <= '0;
            if_id_pc_next_q     <= '0;
            if_id_instr_q       <= '0;
            if_id_pred_taken_q  <= 1'b0;
            if_id_pred_target_q <= '0;
        end else begin
            if_id_pc_curr_q     <= pc_q;
            if_id_pc_next_q     <= pc_plus2;
            if_id_instr_q       <= instr_data;
            if_id_pred_taken_q  <= pred_taken;
            if_id_pred_target_q <= pred_target;
        end
    end

    assign PC_curr           = pc_q;
    assign IF_ID_PC_curr     = if_id_pc_curr_q;
    assign IF_ID_PC_next     = if_id_pc_next_q;
    assign IF_ID_instr       = if_id_instr_q;
    assign IF_ID_pred_taken  = if_id_pred_taken_q;
    assign IF_ID_pred_target = if_id_pred_target_q;

endmodule

// File: tb/tb_fetch_predict_unit.sv
// Directed bench for fetch_predict_unit: fetch sequencing, BTB training, redirects, HLT, flush, wrap, reset.
module tb_fetch_predict_unit;

    logic        clk;
    logic        rst;
    logic        PC_stall;
    logic        IF_ID_stall;
    logic        IF_flush;
    logic        update_PC;
    logic [15:0] actual_target;
    logic        ID_is_branch;
    logic        ID_taken;
    logic [15:0] ID_PC_curr;
    logic [15:0] ID_branch_target;
    logic [15:0] instr_data;
    logic [15:0] PC_curr;
    logic [15:0] IF_ID_PC_curr;
    logic [15:0] IF_ID_PC_next;
    logic [15:0] IF_ID_instr;
    logic        IF_ID_pred_taken;
    logic [15:0] IF_ID_pred_target;

    int checks = 0;
    int errors = 0;

    fetch_predict_unit dut (
        .clk               (clk),
        .rst               (rst),
        .PC_stall          (PC_stall),
        .IF_ID_stall       (IF_ID_stall),
        .IF_flush          (IF_flush),
        .update_PC         (update_PC),
        .actual_target     (actual_target),
        .ID_is_branch      (ID_is_branch),
        .ID_taken          (ID_taken),
        .ID_PC_curr        (ID_PC_curr),
        .ID_branch_target  (ID_branch_target),
        .instr_data        (instr_data),
        .PC_curr           (PC_curr),
        .IF_ID_PC_curr     (IF_ID_PC_curr),
        .IF_ID_PC_next     (IF_ID_PC_next),
        .IF_ID_instr       (IF_ID_instr),
        .IF_ID_pred_taken  (IF_ID_pred_taken),
        .IF_ID_pred_target (IF_ID_pred_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_ctl();
        PC_stall     = 1'b0;
        IF_ID_stall  = 1'b0;
        IF_flush     = 1'b0;
        update_PC    = 1'b0;
        ID_is_branch = 1'b0;
        ID_taken     = 1'b0;
    endtask

    task automatic redirect(input logic [15:0] tgt);
        update_PC     = 1'b1;
        actual_target = tgt;
        step();
        update_PC     = 1'b0;
    endtask

    initial begin
        clear_ctl();
        rst              = 1'b1;
        actual_target    = 16'h0000;
        ID_PC_curr       = 16'h0000;
        ID_branch_target = 16'h0000;
        instr_data       = 16'h1234;

        // Reset state
        step();
        check("rst_pc", PC_curr, 16'h0000);
        check("rst_ifid_pc", IF_ID_PC_curr, 16'h0000);
        check("rst_ifid_next", IF_ID_PC_next, 16'h0000);
        check("rst_ifid_instr", IF_ID_instr, 16'h0000);
        check("rst_ifid_pred", 16'(IF_ID_pred_taken), 16'h0000);
        check("rst_ifid_ptgt", IF_ID_pred_target, 16'h0000);

        // Sequential fetch
        rst = 1'b0;
        step();
        check("seq_pc1", PC_curr, 16'h0002);
        check("seq_ifid_pc", IF_ID_PC_curr, 16'h0000);
        check("seq_ifid_next", IF_ID_PC_next, 16'h0002);
        check("seq_ifid_instr", IF_ID_instr, 16'h1234);
        check("seq_ifid_pred", 16'(IF_ID_pred_taken), 16'h0000);
        step();
        check("seq_pc2", PC_curr, 16'h0004);

        // Redirect to 0x0010 while the taken branch at 0x0010 allocates
        update_PC        = 1'b1;
        actual_target    = 16'h0010;
        ID_is_branch     = 1'b1;
        ID_taken         = 1'b1;
        ID_PC_curr       = 16'h0010;
        ID_branch_target = 16'h0040;
        step();
        clear_ctl();
        check("alloc_redirect_pc", PC_curr, 16'h0010);
        check("alloc_ifid_next", IF_ID_PC_next, 16'h0006);
        step();
        check("pred_pc", PC_curr, 16'h0040);
        check("pred_ifid_pc", IF_ID_PC_curr, 16'h0010);
        check("pred_ifid_taken", 16'(IF_ID_pred_taken), 16'h0001);
        check("pred_ifid_tgt", IF_ID_pred_target, 16'h0040);

        // Train: three taken (saturate 11), one not-taken (10)
        PC_stall     = 1'b1;
        ID_is_branch = 1'b1;
        ID_taken     = 1'b1;
        step(); step(); step();
        check("stall_hold_pc", PC_curr, 16'h0040);
        ID_taken = 1'b0;
        step();
        // Not-taken updates blocked by IF_ID_stall; IF/ID holds
        IF_ID_stall = 1'b1;
        instr_data  = 16'h5555;
        step(); step();
        check("ifid_stall_hold", IF_ID_instr, 16'h1234);
        check("ifid_stall_hold_pc", IF_ID_PC_curr, 16'h0040);
        clear_ctl();
        instr_data = 16'h1234;
        redirect(16'h0010);
        check("sat_redirect_pc", PC_curr, 16'h0010);
        step();
        check("sat_still_taken", PC_curr, 16'h0040);
        // One more not-taken: counter 01
        PC_stall     = 1'b1;
        ID_is_branch = 1'b1;
        ID_taken     = 1'b0;
        step();
        clear_ctl();
        redirect(16'h0010);
        step();
        check("sat_not_taken_pc", PC_curr, 16'h0012);
        check("sat_not_taken_pred", 16'(IF_ID_pred_taken), 16'h0000);

        // Same-index update and lookup in one cycle: lookup sees old contents
        ID_is_branch     = 1'b1;
        ID_taken         = 1'b1;
        ID_PC_curr       = 16'h0012;
        ID_branch_target = 16'h0080;
        step();
        clear_ctl();
        check("bypass_old_pc", PC_curr, 16'h0014);
        check("bypass_old_pred", 16'(IF_ID_pred_taken), 16'h0000);
        redirect(16'h0012);
        step();
        check("bypass_new_pc", PC_curr, 16'h0080);
        check("bypass_new_ptgt", IF_ID_pred_target, 16'h0080);

        // Redirect versus stall
        PC_stall      = 1'b1;
        update_PC     = 1'b1;
        actual_target = 16'h0100;
        step();
        check("redir_stall_hold", PC_curr, 16'h0080);
        PC_stall = 1'b0;
        step();
        clear_ctl();
        check("redir_taken", PC_curr, 16'h0100);

        // HLT holds, flush clears IF/ID, redirect resumes
        redirect(16'h0020);
        instr_data = 16'hF000;
        step();
        check("hlt_hold1", PC_curr, 16'h0020);
        check("hlt_ifid_instr", IF_ID_instr, 16'hF000);
        step();
        check("hlt_hold2", PC_curr, 16'h0020);
        IF_flush = 1'b1;
        step();
        IF_flush = 1'b0;
        check("flush_instr", IF_ID_instr, 16'h0000);
        check("flush_pc", IF_ID_PC_curr, 16'h0000);
        check("flush_hlt_pc", PC_curr, 16'h0020);
        redirect(16'h0030);
        check("hlt_resume", PC_curr, 16'h0030);
        instr_data = 16'h1234;
        step();
        check("hlt_resume_seq", PC_curr, 16'h0032);

        // Wrap-around
        redirect(16'hFFFE);
        check("wrap_pre", PC_curr, 16'hFFFE);
        step();
        check("wrap_pc", PC_curr, 16'h0000);
        check("wrap_ifid_next", IF_ID_PC_next, 16'h0000);
        step();
        check("wrap_seq", PC_curr, 16'h0002);

        // Reset mid-run overrides stall, flush, redirect and a pending BTB update
        rst              = 1'b1;
        PC_stall         = 1'b1;
        IF_flush         = 1'b1;
        update_PC        = 1'b1;
        actual_target    = 16'h0500;
        ID_is_branch     = 1'b1;
        ID_taken         = 1'b1;
        ID_PC_curr       = 16'h0002;
        ID_branch_target = 16'h0200;
        step();
        clear_ctl();
        rst = 1'b0;
        check("mid_rst_pc", PC_curr, 16'h0000);
        check("mid_rst_ifid_pc", IF_ID_PC_curr, 16'h0000);
        step();
        check("post_rst_pc1", PC_curr, 16'h0002);
        step();
        check("post_rst_no_alloc", PC_curr, 16'h0004);
        check("post_rst_pred", 16'(IF_ID_pred_taken), 16'h0000);
        redirect(16'h0010);
        step();
        check("post_rst_inval0", PC_curr, 16'h0012);
        step();
        check("post_rst_inval1", PC_curr, 16'h0014);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
